// File: rtl/hsv_class_stream.sv
// Two-stage HSV pixel classifier with frame-synchronous programmable hue
// classes and a per-frame class histogram that is snapshotted at end of frame.
module hsv_class_stream #(
  parameter int N_CLASSES   = 4,
  parameter int CNT_W       = 20,
  parameter int S_BLACK_MAX = 60,
  parameter int V_BLACK_MAX = 50,
  parameter int CLS_W       = $clog2(N_CLASSES + 2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic                 in_eof,
  input  logic [8:0]           in_h,
  input  logic [7:0]           in_s,
  input  logic [7:0]           in_v,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_class,
  input  logic [1:0]           cfg_field,
  input  logic [15:0]          cfg_wdata,
  output logic                 out_valid,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic [CLS_W-1:0]     out_class,
  output logic [N_CLASSES-1:0] out_onehot,
  input  logic [CLS_W-1:0]     stat_sel,
  output logic [CNT_W-1:0]     stat_count,
  output logic                 stats_valid
);

  localparam int               N_CODES   = N_CLASSES + 2;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [7:0]       S_BLK     = 8'(S_BLACK_MAX);
  localparam logic [7:0]       V_BLK     = 8'(V_BLACK_MAX);
  localparam logic [8:0]       H_MAX     = 9'd359;
  localparam logic [7:0]       S_MIN_DEF = 8'd60;
  localparam logic [7:0]       V_MIN_DEF = 8'd50;

  function automatic logic [8:0] def_lo(input logic [2:0] k);
    case (k)
      3'd0:    return 9'd350;
      3'd1:    return 9'd80;
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic [8:0] def_hi(input logic [2:0] k);
    case (k)
      3'd0:    return 9'd40;
      3'd1:    return 9'd140;
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic def_en(input logic [2:0] k);
    case (k)
      3'd0, 3'd1: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  // A window with lo > hi wraps through 0 degrees.
  function automatic logic class_hit(input logic [8:0] h, input logic [7:0] s, input logic [7:0] v,
                                     input logic [8:0] lo, input logic [8:0] hi,
                                     input logic [7:0] smin, input logic [7:0] vmin, input logic en);
    logic win;
    if (lo <= hi) win = (h >= lo) && (h <= hi);
    else          win = (h >= lo) || (h <= hi);
    return en && (s > smin) && (v > vmin) && (h <= H_MAX) && win;
  endfunction

  logic [8:0]           sh_lo_r   [N_CLASSES];
  logic [8:0]           sh_hi_r   [N_CLASSES];
  logic [7:0]           sh_smin_r [N_CLASSES];
  logic [7:0]           sh_vmin_r [N_CLASSES];
  logic [N_CLASSES-1:0] sh_en_r;
  logic [8:0]           act_lo_r   [N_CLASSES];
  logic [8:0]           act_hi_r   [N_CLASSES];
  logic [7:0]           act_smin_r [N_CLASSES];
  logic [7:0]           act_vmin_r [N_CLASSES];
  logic [N_CLASSES-1:0] act_en_r;

  logic                 commit_s;
  logic [N_CLASSES-1:0] match_s;
  logic                 black_s;
  logic                 s1_valid_r, s1_sof_r, s1_eof_r, s1_black_r;
  logic [N_CLASSES-1:0] s1_match_r;
  logic [CLS_W-1:0]     cls_s;
  logic [CNT_W-1:0]     cnt_r      [N_CODES];
  logic [CNT_W-1:0]     cnt_next_s [N_CODES];
  logic [CNT_W-1:0]     snap_r     [N_CODES];
  logic [CNT_W-1:0]     rd_s;

  assign commit_s = in_valid & in_sof;

  // Shadow config writes; indices at or beyond N_CLASSES match no slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CLASSES; k++) begin
        sh_lo_r[k]   <= def_lo(3'(k));
        sh_hi_r[k]   <= def_hi(3'(k));
        sh_smin_r[k] <= S_MIN_DEF;
        sh_vmin_r[k] <= V_MIN_DEF;
        sh_en_r[k]   <= def_en(3'(k));
      end
    end else begin
      for (int k = 0; k < N_CLASSES; k++) begin
        if (cfg_we && (cfg_class == 3'(k))) begin
          case (cfg_field)
            2'd0: sh_lo_r[k] <= cfg_wdata[8:0];
            2'd1: sh_hi_r[k] <= cfg_wdata[8:0];
            2'd2: begin
              sh_smin_r[k] <= cfg_wdata[15:8];
              sh_vmin_r[k] <= cfg_wdata[7:0];
            end
            default: sh_en_r[k] <= cfg_wdata[0];
          endcase
        end
      end
    end
  end

  // Active config follows the shadow at every start-of-frame pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CLASSES; k++) begin
        act_lo_r[k]   <= def_lo(3'(k));
        act_hi_r[k]   <= def_hi(3'(k));
        act_smin_r[k] <= S_MIN_DEF;
        act_vmin_r[k] <= V_MIN_DEF;
        act_en_r[k]   <= def_en(3'(k));
      end
    end else if (commit_s) begin
      for (int k = 0; k < N_CLASSES; k++) begin
        act_lo_r[k]   <= sh_lo_r[k];
        act_hi_r[k]   <= sh_hi_r[k];
        act_smin_r[k] <= sh_smin_r[k];
        act_vmin_r[k] <= sh_vmin_r[k];
        act_en_r[k]   <= sh_en_r[k];
      end
    end
  end

  // Per-class compares; the committing sof pixel already sees the new config.
  always_comb begin
    match_s = '0;
    for (int k = 0; k < N_CLASSES; k++) begin
      match_s[k] = commit_s
        ? class_hit(in_h, in_s, in_v, sh_lo_r[k], sh_hi_r[k], sh_smin_r[k], sh_vmin_r[k], sh_en_r[k])
        : class_hit(in_h, in_s, in_v, act_lo_r[k], act_hi_r[k], act_smin_r[k], act_vmin_r[k], act_en_r[k]);
    end
    black_s = (in_s <= S_BLK) && (in_v <= V_BLK);
  end

  // Stage 1 register: compare results, data held across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_sof_r   <= 1'b0;
      s1_eof_r   <= 1'b0;
      s1_match_r <= '0;
      s1_black_r <= 1'b0;
    end else begin
      s1_valid_r <= in_valid;
      s1_sof_r   <= in_valid & in_sof;
      s1_eof_r   <= in_valid & in_eof;
      if (in_valid) begin
        s1_match_r <= match_s;
        s1_black_r <= black_s;
      end
    end
  end

  // Priority encode: lowest matching class wins, then black, then none.
  always_comb begin
    cls_s = s1_black_r ? CLS_W'(N_CLASSES) : CLS_W'(N_CLASSES + 1);
    for (int k = N_CLASSES - 1; k >= 0; k--) begin
      cls_s = s1_match_r[k] ? CLS_W'(k) : cls_s;
    end
  end

  // Stage 2 register: classified pixel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_class  <= '0;
      out_onehot <= '0;
    end else begin
      out_valid <= s1_valid_r;
      out_sof   <= s1_sof_r;
      out_eof   <= s1_eof_r;
      if (s1_valid_r) begin
        out_class  <= cls_s;
        out_onehot <= s1_match_r;
      end
    end
  end

  // Histogram update: sof restarts the frame with this pixel counted once.
  always_comb begin
    for (int c = 0; c < N_CODES; c++) begin
      cnt_next_s[c] = cnt_r[c];
      if (out_valid) begin
        if (out_sof) cnt_next_s[c] = (out_class == CLS_W'(c)) ? CNT_ONE : '0;
        else if ((out_class == CLS_W'(c)) && (cnt_r[c] != CNT_MAX)) cnt_next_s[c] = cnt_r[c] + CNT_ONE;
        else cnt_next_s[c] = cnt_r[c];
      end else begin
        cnt_next_s[c] = cnt_r[c];
      end
    end
    rd_s = '0;
    for (int c = 0; c < N_CODES; c++) begin
      rd_s = (stat_sel == CLS_W'(c)) ? snap_r[c] : rd_s;
    end
  end

  // Counters, eof snapshot and registered statistic read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CODES; c++) begin
        cnt_r[c]  <= '0;
        snap_r[c] <= '0;
      end
      stats_valid <= 1'b0;
      stat_count  <= '0;
    end else begin
      for (int c = 0; c < N_CODES; c++) begin
        cnt_r[c] <= cnt_next_s[c];
        if (out_valid && out_eof) snap_r[c] <= cnt_next_s[c];
      end
      stats_valid <= out_valid & out_eof;
      stat_count  <= rd_s;
    end
  end

endmodule
